vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_delay_line.sv | 47 ++++
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default raster timings (800x600@72, 640x480@60), the delay-line
//            payload type and the axis-total helper shared by the VGA block.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int unsigned SVGA_H_ACTIVE  = 800;
  localparam int unsigned SVGA_H_FRONT   = 56;
  localparam int unsigned SVGA_H_SYNC    = 120;
  localparam int unsigned SVGA_H_BACK    = 64;
  localparam int unsigned SVGA_V_ACTIVE  = 600;
  localparam int unsigned SVGA_V_FRONT   = 37;
  localparam int unsigned SVGA_V_SYNC    = 6;
  localparam int unsigned SVGA_V_BACK    = 23;
  localparam logic        SVGA_HSYNC_POL = 1'b1;
  localparam logic        SVGA_VSYNC_POL = 1'b1;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int unsigned VGA_H_ACTIVE   = 640;
  localparam int unsigned VGA_H_FRONT    = 16;
  localparam int unsigned VGA_H_SYNC     = 96;
  localparam int unsigned VGA_H_BACK     = 48;
  localparam int unsigned VGA_V_ACTIVE   = 480;
  localparam int unsigned VGA_V_FRONT    = 10;
  localparam int unsigned VGA_V_SYNC     = 2;
  localparam int unsigned VGA_V_BACK     = 33;
  localparam logic        VGA_HSYNC_POL  = 1'b0;
  localparam logic        VGA_VSYNC_POL  = 1'b0;

  // Supported pixel-source latency range
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 4;

  // Raw (polarity-free) timing bits carried down the latency-matching line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
  } sync_bits_t;

  // Total clocks (or lines) of one axis
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Purpose  : ce-gated shift register of parametrised width and depth with a
//            synchronous clear; matches raster timing to pixel-source latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Stages packed into one vector, newest entry in the low slice
  logic [WIDTH*DEPTH-1:0] r_pipe;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: plain enabled register
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe <= '0;
        end else if (ce) begin
          r_pipe <= din;
        end
      end
    end else begin : g_multi
      // Shift one slice per enabled clock
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe <= '0;
        end else if (ce) begin
          r_pipe <= {r_pipe[WIDTH*(DEPTH-1)-1:0], din};
        end
      end
    end
  endgenerate

  assign dout = r_pipe[WIDTH*DEPTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster generator. Issues pixel requests LAT
//            enabled clocks ahead, delays sync/blank to match the source and
//            registers the final colour, sync and in_view outputs.
//            Optional macro TEST_PATTERN_EN replaces pixel_in with eight
//            vertical colour bars for board bring-up.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = SVGA_H_ACTIVE,
  parameter int unsigned H_FRONT   = SVGA_H_FRONT,
  parameter int unsigned H_SYNC    = SVGA_H_SYNC,
  parameter int unsigned H_BACK    = SVGA_H_BACK,
  parameter int unsigned V_ACTIVE  = SVGA_V_ACTIVE,
  parameter int unsigned V_FRONT   = SVGA_V_FRONT,
  parameter int unsigned V_SYNC    = SVGA_V_SYNC,
  parameter int unsigned V_BACK    = SVGA_V_BACK,
  parameter logic        HSYNC_POL = SVGA_HSYNC_POL,
  parameter logic        VSYNC_POL = SVGA_VSYNC_POL,
  parameter int unsigned COLOR_W   = 6,
  parameter int unsigned LAT       = 2,
  localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int unsigned CW_H     = $clog2(H_TOTAL),
  localparam int unsigned CW_V     = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic [CW_H-1:0]    req_x,
  output logic [CW_V-1:0]    req_y,
  output logic               req_valid,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic               frame_start,
  output logic               line_start,
  output logic [COLOR_W-1:0] vga_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               in_view
);

  // Refuse to elaborate with zero-length porches/syncs or unsupported latency
  generate
    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        LAT < LAT_MIN || LAT > LAT_MAX) begin : g_param_check
      $error("vga_timing_gen: illegal porch/sync/LAT parameter");
    end
  endgenerate

  // Axis boundaries sized to the counters
  localparam logic [CW_H-1:0] c_h_last     = CW_H'(H_TOTAL - 1);
  localparam logic [CW_H-1:0] c_h_active   = CW_H'(H_ACTIVE);
  localparam logic [CW_H-1:0] c_hs_start   = CW_H'(H_ACTIVE + H_FRONT);
  localparam logic [CW_H-1:0] c_hs_end     = CW_H'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW_V-1:0] c_v_last     = CW_V'(V_TOTAL - 1);
  localparam logic [CW_V-1:0] c_v_active   = CW_V'(V_ACTIVE);
  localparam logic [CW_V-1:0] c_vs_start   = CW_V'(V_ACTIVE + V_FRONT);
  localparam logic [CW_V-1:0] c_vs_end     = CW_V'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CW_H-1:0]    r_x;
  logic [CW_V-1:0]    r_y;
  logic               w_valid;
  sync_bits_t         w_raw;
  sync_bits_t         w_dly_sync;
  logic [COLOR_W-1:0] w_pix;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_view;
  logic [COLOR_W-1:0] r_rgb;

  // Request raster position; y steps when x wraps, both wrap together at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (ce) begin
      if (r_x == c_h_last) begin
        r_x <= '0;
        r_y <= (r_y == c_v_last) ? '0 : r_y + CW_V'(1);
      end else begin
        r_x <= r_x + CW_H'(1);
      end
    end
  end

  assign req_x       = r_x;
  assign req_y       = r_y;
  assign w_valid     = (r_x < c_h_active) && (r_y < c_v_active);
  assign req_valid   = w_valid;
  assign line_start  = (r_x == '0);
  assign frame_start = (r_x == '0) && (r_y == '0);

  assign w_raw.hsync = (r_x >= c_hs_start) && (r_x < c_hs_end);
  assign w_raw.vsync = (r_y >= c_vs_start) && (r_y < c_vs_end);
  assign w_raw.valid = w_valid;

`ifdef TEST_PATTERN_EN
  // Pattern mode also needs the requested x alongside the timing bits
  localparam int unsigned c_dly_w = $bits(sync_bits_t) + CW_H;
  logic [c_dly_w-1:0] w_dly_in;
  logic [c_dly_w-1:0] w_dly_out;
  logic [CW_H-1:0]    w_dly_x;
  logic [2:0]         w_bar;

  assign w_dly_in              = {w_raw, r_x};
  assign {w_dly_sync, w_dly_x} = w_dly_out;

  // Bar index is x*8/H_ACTIVE (threshold compares); colour repeats ~index so bar 0 is white
  always_comb begin
    w_bar = 3'd0;
    for (int b = 1; b < 8; b++) begin
      if (w_dly_x >= CW_H'((b * H_ACTIVE + 7) / 8)) begin
        w_bar = 3'(b);
      end
    end
    w_pix = '0;
    for (int i = 0; i < COLOR_W; i++) begin
      w_pix[i] = ~w_bar[i % 3];
    end
  end
`else
  localparam int unsigned c_dly_w = $bits(sync_bits_t);
  logic [c_dly_w-1:0] w_dly_in;
  logic [c_dly_w-1:0] w_dly_out;

  assign w_dly_in   = w_raw;
  assign w_dly_sync = w_dly_out;
  assign w_pix      = pixel_in;
`endif

  // Delay raw timing by LAT so it lines up with the colour returned by the source
  vga_delay_line #(
    .WIDTH (c_dly_w),
    .DEPTH (LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  (w_dly_in),
    .dout (w_dly_out)
  );

  // Output stage: applies sync polarity, blanks colour outside the active area
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_view  <= 1'b0;
      r_rgb   <= '0;
    end else if (ce) begin
      r_hsync <= w_dly_sync.hsync ^~ HSYNC_POL;
      r_vsync <= w_dly_sync.vsync ^~ VSYNC_POL;
      r_view  <= w_dly_sync.valid;
      r_rgb   <= w_dly_sync.valid ? w_pix : '0;
    end
  end

  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign in_view = r_view;
  assign vga_rgb = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Scoreboard bench for vga_timing_gen on a reduced raster
//            (H 20/3/4/2 = 29 clocks, V 5/2/2/1 = 10 lines, LAT=3,
//            hsync active-high, vsync active-low).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int LAT   = 3;
  localparam int H_TOT = 29;
  localparam int V_TOT = 10;

  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
    logic       iv;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [4:0] req_x;
  logic [3:0] req_y;
  logic       req_valid;
  logic [5:0] pixel_in;
  logic       frame_start;
  logic       line_start;
  logic [5:0] vga_rgb;
  logic       hsync;
  logic       vsync;
  logic       in_view;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mx, my;
  bit   started  = 1'b0;
  bit   win_on;
  int   cnt_hs = 0, cnt_vs = 0, cnt_iv = 0, cnt_fs = 0;
  out_t exp_q[$];
  out_t last_exp;
  out_t idle_exp;
  logic [6*LAT-1:0] src_pipe;

  vga_timing_gen #(
    .H_ACTIVE (20), .H_FRONT (3), .H_SYNC (4), .H_BACK (2),
    .V_ACTIVE (5),  .V_FRONT (2), .V_SYNC (2), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0),
    .COLOR_W (6), .LAT (LAT)
  ) dut (
    .clk (clk), .rst (rst), .ce (ce),
    .req_x (req_x), .req_y (req_y), .req_valid (req_valid),
    .pixel_in (pixel_in),
    .frame_start (frame_start), .line_start (line_start),
    .vga_rgb (vga_rgb), .hsync (hsync), .vsync (vsync), .in_view (in_view)
  );

  always #5 clk = ~clk;

  // Registered pixel source: colour = {y[0], x} returned LAT enabled clocks later
  always @(posedge clk) begin
    if (rst) src_pipe <= '0;
    else if (ce) src_pipe <= {src_pipe[6*LAT-7:0], req_y[0], req_x};
  end
  assign pixel_in = src_pipe[6*LAT-1 -: 6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-derived outputs for a request at (x,y) on the reduced raster
  function automatic out_t expect_for(input int x, input int y);
    out_t e;
    bit   v;
    v     = (x < 20) && (y < 5);
    e.rgb = v ? 6'((y % 2) * 32 + x) : 6'd0;
    e.hs  = (x >= 23 && x < 27) ? 1'b1 : 1'b0;
    e.vs  = (y >= 7 && y < 9)   ? 1'b0 : 1'b1;
    e.iv  = v;
    return e;
  endfunction

  // Reference raster counter; pushes the expected display of each issued request
  always @(posedge clk) begin
    if (rst) begin
      mx <= 0;
      my <= 0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back(idle_exp);
    end else if (ce) begin
      exp_q.push_back(expect_for(mx, my));
      if (mx == H_TOT - 1) begin
        mx <= 0;
        my <= (my == V_TOT - 1) ? 0 : my + 1;
      end else begin
        mx <= mx + 1;
      end
    end
  end

  // Monitor: pops one expectation per enabled clock, checks holds and reset state
  always begin
    bit   s_rst, s_ce, s_win;
    out_t e;
    @(posedge clk);
    s_rst = rst;
    s_ce  = ce;
    s_win = win_on;
    #1;
    if (s_rst) begin
      started  = 1'b1;
      last_exp = idle_exp;
      check("rst_rgb", vga_rgb, 0);
      check("rst_hsync", hsync, 0);
      check("rst_vsync", vsync, 1);
      check("rst_in_view", in_view, 0);
      check("rst_req_x", req_x, 0);
      check("rst_req_y", req_y, 0);
      check("rst_frame_start", frame_start, 1);
      check("rst_req_valid", req_valid, 1);
    end else if (started) begin
      if (s_ce) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got empty queue expected entry");
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
        end
      end
      check("vga_rgb", vga_rgb, last_exp.rgb);
      check("hsync", hsync, last_exp.hs);
      check("vsync", vsync, last_exp.vs);
      check("in_view", in_view, last_exp.iv);
      check("req_x", req_x, mx);
      check("req_y", req_y, my);
      check("req_valid", req_valid, (mx < 20) && (my < 5));
      check("line_start", line_start, mx == 0);
      check("frame_start", frame_start, (mx == 0) && (my == 0));
      if (s_ce && s_win) begin
        cnt_hs += (hsync == 1'b1);
        cnt_vs += (vsync == 1'b0);
        cnt_iv += in_view;
        cnt_fs += frame_start;
      end
    end
  end

  // Directed stimulus: free run, ce stretching, irregular ce, mid-frame reset
  initial begin
    bit found;
    idle_exp = '{rgb: 6'd0, hs: 1'b0, vs: 1'b1, iv: 1'b0};
    rst    = 1'b1;
    ce     = 1'b1;
    win_on = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Two whole frames (580 enabled clocks) counted after latency settles
    repeat (10) @(negedge clk);
    win_on = 1'b1;
    repeat (580) @(negedge clk);
    win_on = 1'b0;
    @(negedge clk);
    check("hsync_active_clocks", cnt_hs, 80);   // 2 frames * 10 lines * 4
    check("vsync_active_clocks", cnt_vs, 116);  // 2 frames * 2 lines * 29
    check("in_view_clocks", cnt_iv, 200);       // 2 frames * 5 lines * 20
    check("frame_start_pulses", cnt_fs, 2);

    // ce alternating 1/0: same sequence stretched 2x, holds on ce=0
    for (int i = 0; i < 1160; i++) begin
      ce = (i % 2) == 0;
      @(negedge clk);
    end

    // ce three-on one-off
    for (int i = 0; i < 400; i++) begin
      ce = (i % 4) != 3;
      @(negedge clk);
    end

    // Reset in the middle of an active line at (12,3)
    ce    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (mx == 12 && my == 3) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL midframe_wait: got no (12,3) expected reached within 400 clocks");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (320) @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
